disp_buf_reader: RTL and testbench
==================================

Name: disp_buf_reader

Overview:
- Read-side engine for the dual-port display buffer RAM.
- On each frame strobe, sweeps NUM_CHARS consecutive buffer locations through the RAM read port. The port has 1-cycle registered read latency with a read enable.
- Presents each character on a valid/ready stream to the display/printer driver.
- Tags each character with its index and a last flag.

Parameters:
MEM_WIDTH, 8, data width of RAM word and output character
ADDR_WIDTH, 10, RAM read address width
BASE_ADDR, 0, first buffer address swept per frame
NUM_CHARS, 20, characters per frame (>=1)
IDX_WIDTH, $clog2(NUM_CHARS) (min 1), width of ch_idx

Ports:
rd_clk  input  1  sole clock; rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  frame strobe, single-cycle pulse
busy  output  1  high from accepted start until final handshake
re  output  1  RAM read enable
r_addr  output  ADDR_WIDTH  RAM read address
r_data  input  MEM_WIDTH  RAM read data, valid the cycle after re
ch_valid  output  1  character available
ch_ready  input  1  downstream accepts character
ch_data  output  MEM_WIDTH  character
ch_idx  output  IDX_WIDTH  position 0..NUM_CHARS-1
ch_last  output  1  high with index NUM_CHARS-1
overrun  output  1  one-cycle pulse: start received while busy

Behaviour:
- Interface: one clock, rd_clk; reset is asynchronous, active-high, port named reset.
- Reset values, all outputs 0: busy, re, r_addr, ch_valid, ch_data, ch_idx, ch_last, overrun. Internal index = 0; state = IDLE.
- Reset mid-frame aborts the sweep immediately. No partial character is emitted after reset release.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE:
  - busy=0.
  - start=1 -> index=0, ISSUE next cycle; busy=1 from that cycle.
- ISSUE:
  - re=1 for exactly this cycle.
  - r_addr = (BASE_ADDR + index) mod 2^ADDR_WIDTH; the address wraps silently.
  - -> CAPTURE.
- CAPTURE:
  - re=0.
  - r_data registered into ch_data.
  - ch_idx = index; ch_last = (index == NUM_CHARS-1); ch_valid=1 from next cycle.
  - -> HOLD.
- HOLD:
  - ch_valid=1; ch_data/ch_idx/ch_last stable until handshake.
  - Handshake = ch_valid & ch_ready at a rising edge.
  - Handshake with ch_last=0 -> ch_valid=0, index+1, ISSUE.
  - Handshake with ch_last=1 -> ch_valid=0, busy=0, IDLE.
  - ch_ready without ch_valid is ignored.
- Timing:
  - Start-to-first-valid latency: 3 cycles (start edge -> ISSUE -> CAPTURE -> HOLD).
  - With ch_ready held high: one character per 3 cycles; a frame takes 3*NUM_CHARS cycles.
- r_addr holds its last driven value when re=0. re is never asserted outside ISSUE.
- start while busy (any non-IDLE state): ignored, and overrun=1 for one cycle.
- start in the same cycle as the final handshake: treated as while-busy, so it is ignored with overrun.
- start in IDLE the cycle after the final handshake is accepted normally.
- NUM_CHARS=1: first character has ch_last=1, ch_idx=0.
- No combinational path from ch_ready or start to any output. All outputs are registered.

Test Plan:
- RAM preloaded 0x41..0x54 at 0..19, defaults, ch_ready=1, one start pulse -> re pulses at addrs 0..19 every 3 cycles; stream 0x41..0x54 with idx 0..19; ch_last only with 0x54; busy falls after the 20th handshake; first ch_valid 3 cycles after start.
- Same frame, ch_ready held low 5 cycles on idx 7 -> ch_valid/ch_data=0x48/ch_idx=7 stable for all 5 cycles; no re pulse until handshake; no duplicate or skipped characters.
- BASE_ADDR=1020, ADDR_WIDTH=10, NUM_CHARS=8 -> r_addr sequence 1020,1021,1022,1023,0,1,2,3.
- start pulsed at cycle 10 of a frame and again coincident with the final handshake -> overrun pulses twice, frame output unchanged, busy low after the final handshake.
- reset asserted asynchronously mid-HOLD at idx 12 -> all outputs 0 immediately. New start after release yields idx 0 at BASE_ADDR.
- RAM location 5 rewritten via write port between frames, 0x46->0x7E, then second start -> second frame idx 5 carries 0x7E; all other characters unchanged.

Source files
------------

// File: rtl/disp_buf_reader.sv
// Read-side sweep engine for the display buffer RAM: fetches NUM_CHARS words per
// frame strobe and streams them out as indexed characters on a valid/ready port.
module disp_buf_reader #(
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_CHARS  = 20,
    parameter int IDX_WIDTH  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [MEM_WIDTH-1:0]  r_data,
    output logic                  ch_valid,
    input  logic                  ch_ready,
    output logic [MEM_WIDTH-1:0]  ch_data,
    output logic [IDX_WIDTH-1:0]  ch_idx,
    output logic                  ch_last,
    output logic                  overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CHARS - 1);

    logic [1:0]           state;
    logic [IDX_WIDTH-1:0] index;
    logic [IDX_WIDTH-1:0] index_next;

    assign index_next = index + IDX_WIDTH'(1);

    // Address arithmetic is done at ADDR_WIDTH so the sweep wraps modulo the RAM size.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_WIDTH-1:0] i);
        return BASE + ADDR_WIDTH'(i);
    endfunction

    // re is registered, so it is raised on the edge that enters ISSUE and dropped on the next.
    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            index    <= '0;
            busy     <= 1'b0;
            re       <= 1'b0;
            r_addr   <= '0;
            ch_valid <= 1'b0;
            ch_data  <= '0;
            ch_idx   <= '0;
            ch_last  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= start && (state != S_IDLE);
            re      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index  <= '0;
                        re     <= 1'b1;
                        r_addr <= BASE;
                        busy   <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    ch_data  <= r_data;
                    ch_idx   <= index;
                    ch_last  <= (index == LAST_IDX);
                    ch_valid <= 1'b1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (ch_valid && ch_ready) begin
                        ch_valid <= 1'b0;
                        if (ch_last) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            index  <= index_next;
                            re     <= 1'b1;
                            r_addr <= addr_of(index_next);
                            state  <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_buf_reader.sv
// Directed bench for disp_buf_reader: default frame, stall, overrun, async reset,
// buffer rewrite, address wrap and single-character frames.
module tb_disp_buf_reader;

    logic       rd_clk = 1'b0;
    logic       reset, start, ch_ready;
    logic       busy, re, ch_valid, ch_last, overrun;
    logic [9:0] r_addr;
    logic [7:0] r_data, ch_data;
    logic [4:0] ch_idx;

    logic       start_w, ready_w, busy_w, re_w, valid_w, last_w, ovr_w;
    logic [9:0] r_addr_w;
    logic [7:0] r_data_w, data_w;
    logic [2:0] idx_w;

    logic       start_1, ready_1, busy_1, re_1, valid_1, last_1, ovr_1;
    logic [9:0] r_addr_1;
    logic [7:0] r_data_1, data_1;
    logic [0:0] idx_1;

    logic [7:0] mem  [0:1023];
    logic [7:0] memw [0:1023];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ovr_cyc_g = -1;
    bit pend = 1'b0;

    always #5 rd_clk = ~rd_clk;

    disp_buf_reader dut (
        .rd_clk(rd_clk), .reset(reset), .start(start), .busy(busy), .re(re),
        .r_addr(r_addr), .r_data(r_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_data(ch_data), .ch_idx(ch_idx), .ch_last(ch_last), .overrun(overrun)
    );

    disp_buf_reader #(.BASE_ADDR(1020), .NUM_CHARS(8)) dut_w (
        .rd_clk(rd_clk), .reset(reset), .start(start_w), .busy(busy_w), .re(re_w),
        .r_addr(r_addr_w), .r_data(r_data_w), .ch_valid(valid_w), .ch_ready(ready_w),
        .ch_data(data_w), .ch_idx(idx_w), .ch_last(last_w), .overrun(ovr_w)
    );

    disp_buf_reader #(.BASE_ADDR(3), .NUM_CHARS(1)) dut_1 (
        .rd_clk(rd_clk), .reset(reset), .start(start_1), .busy(busy_1), .re(re_1),
        .r_addr(r_addr_1), .r_data(r_data_1), .ch_valid(valid_1), .ch_ready(ready_1),
        .ch_data(data_1), .ch_idx(idx_1), .ch_last(last_1), .overrun(ovr_1)
    );

    // Registered-read RAM models, one read port per instance.
    always @(posedge rd_clk) begin
        if (re)   r_data   <= mem[r_addr];
        if (re_w) r_data_w <= memw[r_addr_w];
        if (re_1) r_data_1 <= mem[r_addr_1];
    end

    task automatic adv();
        @(negedge rd_clk);
        cyc++;
        n_cmp++;
        if (overrun !== pend) begin
            n_err++;
            $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, pend);
        end
        pend  = 1'b0;
        start = 1'b0;
        if (cyc == ovr_cyc_g) begin
            start = 1'b1;
            pend  = 1'b1;
        end
    endtask

    task automatic run_frame(input int stall_idx, input int stall_len, input int ovr_cyc,
                             input bit ovr_final, input logic [7:0] exp5);
        logic [7:0] exp_d;
        bit hs;
        @(negedge rd_clk);
        cyc = 0;
        pend = 1'b0;
        ovr_cyc_g = ovr_cyc;
        ch_ready = 1'b1;
        start = 1'b1;
        adv();
        for (int j = 0; j < 20; j++) begin
            exp_d = (j == 5) ? exp5 : 8'h41 + 8'(j);
            n_cmp++;
            if ({re, r_addr, busy, ch_valid} !== {1'b1, 10'(j), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL issue j=%0d got re=%b addr=%0d busy=%b valid=%b exp re=1 addr=%0d busy=1 valid=0",
                         j, re, r_addr, busy, ch_valid, j);
            end
            adv();
            n_cmp++;
            if ({re, ch_valid, busy} !== 3'b001) begin
                n_err++;
                $display("FAIL capture j=%0d got re=%b valid=%b busy=%b exp 0 0 1", j, re, ch_valid, busy);
            end
            if (j == stall_idx) ch_ready = 1'b0;
            adv();
            for (int h = 0; h <= stall_len + 1; h++) begin
                n_cmp++;
                if ({ch_valid, ch_data, ch_idx, ch_last, re, busy} !==
                    {1'b1, exp_d, 5'(j), (j == 19), 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL hold j=%0d h=%0d got v=%b d=%h i=%0d l=%b re=%b b=%b exp v=1 d=%h i=%0d l=%b re=0 b=1",
                             j, h, ch_valid, ch_data, ch_idx, ch_last, re, busy, exp_d, j, (j == 19));
                end
                if (j == stall_idx && h == stall_len) ch_ready = 1'b1;
                hs = ch_ready;
                if (hs && j == 19 && ovr_final) begin
                    start = 1'b1;
                    pend  = 1'b1;
                end
                adv();
                if (hs) break;
            end
        end
        n_cmp++;
        if ({busy, ch_valid, re} !== 3'b000) begin
            n_err++;
            $display("FAIL frame_end got busy=%b valid=%b re=%b exp 000", busy, ch_valid, re);
        end
        adv();
        n_cmp++;
        if ({busy, re} !== 2'b00) begin
            n_err++;
            $display("FAIL post_idle got busy=%b re=%b exp 00", busy, re);
        end
        ovr_cyc_g = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; ch_ready = 1'b0;
        start_w = 1'b0; ready_w = 1'b0;
        start_1 = 1'b0; ready_1 = 1'b0;
        #12;
        n_cmp++;
        if ({busy, re, r_addr, ch_valid, ch_data, ch_idx, ch_last, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got b=%b re=%b a=%0d v=%b d=%h i=%0d l=%b o=%b exp all 0",
                     busy, re, r_addr, ch_valid, ch_data, ch_idx, ch_last, overrun);
        end
        n_cmp++;
        if ({busy_w, re_w, valid_w, busy_1, re_1, valid_1} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_others got %b exp 000000", {busy_w, re_w, valid_w, busy_1, re_1, valid_1});
        end
        @(negedge rd_clk);
        reset = 1'b0;
    endtask

    task automatic test_frame();
        run_frame(-1, 0, -1, 1'b0, 8'h46);
    endtask

    task automatic test_stall();
        run_frame(7, 5, -1, 1'b0, 8'h46);
    endtask

    task automatic test_overrun();
        run_frame(-1, 0, 10, 1'b1, 8'h46);
    endtask

    task automatic test_reset_mid();
        @(negedge rd_clk);
        cyc = 0; pend = 1'b0; ovr_cyc_g = -1;
        ch_ready = 1'b1;
        start = 1'b1;
        repeat (39) adv();
        n_cmp++;
        if ({ch_valid, ch_idx, ch_data} !== {1'b1, 5'd12, 8'h4D}) begin
            n_err++;
            $display("FAIL pre_reset got v=%b i=%0d d=%h exp v=1 i=12 d=4d", ch_valid, ch_idx, ch_data);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, re, r_addr, ch_valid, ch_data, ch_idx, ch_last, overrun} !== '0) begin
            n_err++;
            $display("FAIL async_reset got b=%b re=%b a=%0d v=%b d=%h i=%0d l=%b o=%b exp all 0",
                     busy, re, r_addr, ch_valid, ch_data, ch_idx, ch_last, overrun);
        end
        @(negedge rd_clk);
        reset = 1'b0;
        run_frame(-1, 0, -1, 1'b0, 8'h46);
    endtask

    task automatic test_rewrite();
        mem[5] = 8'h7E;
        run_frame(-1, 0, -1, 1'b0, 8'h7E);
    endtask

    task automatic test_wrap();
        logic [9:0] aa;
        logic [7:0] ed;
        @(negedge rd_clk);
        start_w = 1'b1; ready_w = 1'b1;
        @(negedge rd_clk);
        start_w = 1'b0;
        for (int j = 0; j < 8; j++) begin
            aa = 10'((1020 + j) % 1024);
            ed = aa[7:0] ^ 8'hA5;
            n_cmp++;
            if ({re_w, r_addr_w, busy_w} !== {1'b1, aa, 1'b1}) begin
                n_err++;
                $display("FAIL wrap_addr j=%0d got re=%b addr=%0d busy=%b exp re=1 addr=%0d busy=1",
                         j, re_w, r_addr_w, busy_w, aa);
            end
            @(negedge rd_clk);
            @(negedge rd_clk);
            n_cmp++;
            if ({valid_w, data_w, idx_w, last_w} !== {1'b1, ed, 3'(j), (j == 7)}) begin
                n_err++;
                $display("FAIL wrap_char j=%0d got v=%b d=%h i=%0d l=%b exp v=1 d=%h i=%0d l=%b",
                         j, valid_w, data_w, idx_w, last_w, ed, j, (j == 7));
            end
            @(negedge rd_clk);
        end
        n_cmp++;
        if ({busy_w, valid_w} !== 2'b00) begin
            n_err++;
            $display("FAIL wrap_end got busy=%b valid=%b exp 00", busy_w, valid_w);
        end
    endtask

    task automatic test_single();
        @(negedge rd_clk);
        start_1 = 1'b1; ready_1 = 1'b1;
        @(negedge rd_clk);
        start_1 = 1'b0;
        n_cmp++;
        if ({re_1, r_addr_1, busy_1} !== {1'b1, 10'd3, 1'b1}) begin
            n_err++;
            $display("FAIL single_issue got re=%b addr=%0d busy=%b exp 1 3 1", re_1, r_addr_1, busy_1);
        end
        @(negedge rd_clk);
        @(negedge rd_clk);
        n_cmp++;
        if ({valid_1, data_1, idx_1, last_1} !== {1'b1, 8'h44, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_char got v=%b d=%h i=%0d l=%b exp v=1 d=44 i=0 l=1", valid_1, data_1, idx_1, last_1);
        end
        @(negedge rd_clk);
        n_cmp++;
        if ({busy_1, valid_1} !== 2'b00) begin
            n_err++;
            $display("FAIL single_end got busy=%b valid=%b exp 00", busy_1, valid_1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = (i < 20) ? 8'h41 + 8'(i) : 8'h00;
            memw[i] = 8'(i) ^ 8'hA5;
        end
        test_reset();
        test_frame();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_rewrite();
        test_wrap();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
